// File: rtl/gemm_job_ctrl.sv
// gemm_job_ctrl: job sequencer in front of the GEMM systolic array.
// Latches a weight matrix and row count on start, loads the weights,
// streams activation rows in, drains the array and forwards result rows.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; weights/row count latched on acceptance
// S_LOAD  | one cycle of CMD_WRITE_WEIGHTS
// S_STREAM| activation rows accepted, array advances only on handshake
// S_DRAIN | zero activations pushed through until last row or timeout
// S_DONE  | one-cycle done pulse, back to idle

typedef enum logic [1:0] {
  CMD_NONE          = 2'd0,
  CMD_WRITE_WEIGHTS = 2'd1,
  CMD_STREAM        = 2'd2
} command_t;

module gemm_job_ctrl #(
  parameter int SA_SIZE                = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int MAX_ROWS               = 16,
  parameter int DRAIN_TIMEOUT          = 4*SA_SIZE+4,
  localparam int W  = WEIGHT_ACTIVATION_SIZE,
  localparam int RW = $clog2(MAX_ROWS+1),
  localparam int DW = $clog2(DRAIN_TIMEOUT+1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [RW-1:0]                        num_rows,
  input  logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] weights_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SA_SIZE-1:0][W-1:0]            in_data,
  output logic                                 out_valid,
  output logic [SA_SIZE-1:0][W-1:0]            out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output command_t                             gemm_cmd,
  output logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] gemm_weight_inputs,
  output logic [SA_SIZE-1:0][W-1:0]            gemm_activation_inputs,
  input  logic [SA_SIZE-1:0][W-1:0]            gemm_activation_outputs,
  input  logic                                 gemm_output_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                               state;
  logic [RW-1:0]                        num_rows_q;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] weights_q;
  logic [RW-1:0]                        in_cnt;
  logic [RW-1:0]                        out_cnt;
  logic [DW-1:0]                        drain_cnt;
  logic                                 hs;
  logic                                 capture;
  logic [RW-1:0]                        num_rows_clamped;

  assign num_rows_clamped   = (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;
  assign in_ready           = (state == S_STREAM) && (in_cnt < num_rows_q);
  assign hs                 = in_valid && in_ready;
  assign busy               = (state != S_IDLE);
  assign done               = (state == S_DONE);
  assign gemm_weight_inputs = weights_q;

  // Array command and activation mux; the array only advances on CMD_STREAM.
  always_comb begin
    gemm_cmd               = CMD_NONE;
    gemm_activation_inputs = '0;
    case (state)
      S_LOAD:   gemm_cmd = CMD_WRITE_WEIGHTS;
      S_STREAM: begin
        if (hs) begin
          gemm_cmd               = CMD_STREAM;
          gemm_activation_inputs = in_data;
        end
      end
      S_DRAIN:  gemm_cmd = CMD_STREAM;
      default:  gemm_cmd = CMD_NONE;
    endcase
  end

  // A result is only consumed in a cycle where the array is also advancing,
  // so a row presented during a bubble is taken exactly once.
  assign capture = gemm_output_valid && (gemm_cmd == CMD_STREAM) && (out_cnt < num_rows_q);

  // Job FSM, counters and registered result stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      num_rows_q <= '0;
      weights_q  <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      drain_cnt  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      error      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= gemm_activation_outputs;
        out_last  <= (out_cnt == num_rows_q - 1'b1);
        out_cnt   <= out_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            weights_q  <= weights_in;
            num_rows_q <= num_rows_clamped;
            error      <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            drain_cnt  <= '0;
            state      <= (num_rows == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: state <= S_STREAM;
        S_STREAM: begin
          if (hs) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == num_rows_q - 1'b1) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          // out_cnt reaches num_rows in the cycle the last row is on out_*,
          // so done lands one cycle after the final out_valid.
          if (out_cnt == num_rows_q) begin
            state <= S_DONE;
          end else if (drain_cnt == DW'(DRAIN_TIMEOUT-1)) begin
            state <= S_DONE;
            error <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
